// File: rtl/host_bus_arbiter.sv
// rtl/host_bus_arbiter.sv - two-master arbiter onto a shared register bus, master A absolute priority
module host_bus_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          host_clk,
    input  logic          host_rst_l,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wr_data,
    input  logic          a_rd_en,
    input  logic          a_wr_en,
    output logic [DW-1:0] a_rd_data,
    output logic          a_rd_valid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wr_data,
    output logic          b_ack,
    output logic [DW-1:0] b_rd_data,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wr_data,
    output logic          s_rd_en,
    output logic          s_wr_en,
    input  logic [DW-1:0] s_rd_data,
    output logic          a_collision
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } b_state_t;

    b_state_t b_state;
    logic     a_rd_pend;
    logic     b_rd_pend;
    logic     a_any;

    assign a_any = a_rd_en | a_wr_en;

    always_ff @(posedge host_clk or negedge host_rst_l) begin
        if (!host_rst_l) begin
            b_state     <= IDLE;
            a_rd_pend   <= 1'b0;
            b_rd_pend   <= 1'b0;
            a_rd_data   <= '0;
            a_rd_valid  <= 1'b0;
            b_ack       <= 1'b0;
            b_rd_data   <= '0;
            s_addr      <= '0;
            s_wr_data   <= '0;
            s_rd_en     <= 1'b0;
            s_wr_en     <= 1'b0;
            a_collision <= 1'b0;
        end else begin
            s_rd_en    <= 1'b0;
            s_wr_en    <= 1'b0;
            b_ack      <= 1'b0;
            a_rd_pend  <= 1'b0;
            a_rd_valid <= a_rd_pend;

            // A read data is returned by the slave in the cycle the strobe is on the bus
            if (a_rd_pend) begin
                a_rd_data <= s_rd_data;
            end

            if (a_any) begin
                s_addr <= a_addr;
                if (a_wr_en) begin
                    s_wr_en   <= 1'b1;
                    s_wr_data <= a_wr_data;
                end else begin
                    s_rd_en   <= 1'b1;
                    a_rd_pend <= 1'b1;
                end
                if (a_rd_en && a_wr_en) begin
                    a_collision <= 1'b1;
                end
            end

            // B only launches in a cycle with no A strobe, so the bus never carries both
            case (b_state)
                IDLE: begin
                    if (b_req && !a_any) begin
                        b_state   <= BUSY;
                        b_rd_pend <= ~b_we;
                        s_addr    <= b_addr;
                        if (b_we) begin
                            s_wr_en   <= 1'b1;
                            s_wr_data <= b_wr_data;
                        end else begin
                            s_rd_en <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (b_rd_pend) begin
                        b_rd_data <= s_rd_data;
                    end
                    b_rd_pend <= 1'b0;
                    b_ack     <= 1'b1;
                    b_state   <= DONE;
                end
                DONE: begin
                    b_state <= IDLE;
                end
                default: begin
                    b_state <= IDLE;
                end
            endcase
        end
    end

endmodule
